// File: rtl/tt_sweep_pkg.sv
// Shared types and constants for the truth-table sweep/capture stage.
package tt_sweep_pkg;

  // Default number of inputs of the swept function.
  localparam int N_IN_DEF = 7;

  // Truth-table width for the default input count.
  localparam int TT_W = 2 ** N_IN_DEF;

  // Width of the x_o sweep counter for the default input count.
  localparam int CNT_W = N_IN_DEF;

  // Width of the drain counter (SAMPLE_LAT is limited to 0..3).
  localparam int LAT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Truth-table width for an arbitrary input count.
  function automatic int unsigned tt_width(input int unsigned n_in);
    return 32'd1 << n_in;
  endfunction

endpackage

// File: rtl/tt_sweep_if.sv
// Bus bundle of the sweep stage: function drive/sample pair and the
// result valid/ready handshake towards the classification consumer.
interface tt_sweep_if
  import tt_sweep_pkg::*;
#(
  parameter int N_IN = N_IN_DEF
);

  localparam int TTW = 2 ** N_IN;

  // Function side
  logic [N_IN-1:0] x_o;
  logic            f_i;

  // Result side
  logic [TTW-1:0]  tt_o;
  logic [N_IN:0]   ones_o;
  logic            self_dual_o;
  logic            tt_valid;
  logic            tt_ready;

  // Sweep stage drives vectors and results, samples f and ready.
  modport master (
    output x_o,
    input  f_i,
    output tt_o,
    output ones_o,
    output self_dual_o,
    output tt_valid,
    input  tt_ready
  );

  // Function model / consumer side.
  modport slave (
    input  x_o,
    output f_i,
    input  tt_o,
    input  ones_o,
    input  self_dual_o,
    input  tt_valid,
    output tt_ready
  );

endinterface

// File: rtl/tt_sweep_delay.sv
// Aligns the driven vector index with the returning function sample:
// a DEPTH-deep register line carrying {valid, index}; wires through
// when DEPTH = 0.
module tt_sweep_delay #(
  parameter int DEPTH = 0,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  if (DEPTH == 0) begin : g_pass
    // Clock and reset are not needed for a zero-latency path.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    assign valid_o = valid_i;
    assign idx_o   = idx_i;
  end else begin : g_line
    logic [DEPTH-1:0] v_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Shift the {valid, index} pair one stage per cycle; reset drops
    // any in-flight samples so an aborted sweep leaves nothing behind.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= '0;
        for (int unsigned i = 0; i < DEPTH; i++) idx_q[i] <= '0;
      end else begin
        v_q[0]   <= valid_i;
        idx_q[0] <= idx_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          v_q[i]   <= v_q[i-1];
          idx_q[i] <= idx_q[i-1];
        end
      end
    end

    assign valid_o = v_q[DEPTH-1];
    assign idx_o   = idx_q[DEPTH-1];
  end

endmodule

// File: rtl/tt_sweep_capture.sv
// Truth-table sweep/capture harness around a combinational N_IN-input
// function: drives every input vector in ascending order, captures the
// function output into a 2**N_IN-bit truth table with its ones count,
// and offers the result over a valid/ready handshake.
// Optional macro TT_SELFDUAL_CHECK_EN adds a registered self-duality
// flag computed when the result becomes valid.
module tt_sweep_capture
  import tt_sweep_pkg::*;
#(
  parameter int N_IN       = N_IN_DEF,
  parameter int SAMPLE_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  tt_sweep_if.master bus
);

  localparam int TTW  = 2 ** N_IN;
  localparam int HALF = TTW / 2;

  state_e            state_q, state_d;
  logic [N_IN-1:0]   x_q, x_d;
  logic [TTW-1:0]    tt_q, tt_d;
  logic [N_IN:0]     ones_q, ones_d;
  logic [LAT_W-1:0]  drain_q, drain_d;

  logic              launch;
  logic              drive_valid;
  logic              smp_valid;
  logic [N_IN-1:0]   smp_idx;

  assign launch      = (state_q == IDLE) && start;
  assign drive_valid = (state_q == SWEEP);

  tt_sweep_delay #(
    .DEPTH (SAMPLE_LAT),
    .IDX_W (N_IN)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (drive_valid),
    .idx_i   (x_q),
    .valid_o (smp_valid),
    .idx_o   (smp_idx)
  );

  // Sequencing: next state, sweep counter and drain counter.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    drain_d = drain_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SWEEP;
          x_d     = '0;
        end
      end
      SWEEP: begin
        // Counter wraps to 0 exactly on the last vector.
        x_d = x_q + N_IN'(1);
        if (x_q == '1) begin
          drain_d = '0;
          state_d = (SAMPLE_LAT > 0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        drain_d = drain_q + LAT_W'(1);
        if (drain_q == LAT_W'(SAMPLE_LAT - 1)) state_d = DONE;
      end
      DONE: begin
        if (bus.tt_ready) state_d = IDLE;
      end
    endcase
  end

  // Accumulation: clear on launch, otherwise place each aligned sample.
  always_comb begin
    tt_d   = tt_q;
    ones_d = ones_q;
    if (launch) begin
      tt_d   = '0;
      ones_d = '0;
    end else if (smp_valid) begin
      tt_d[smp_idx] = bus.f_i;
      ones_d        = ones_q + {{N_IN{1'b0}}, bus.f_i};
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      drain_q <= '0;
      tt_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      drain_q <= drain_d;
      tt_q    <= tt_d;
      ones_q  <= ones_d;
    end
  end

`ifdef TT_SELFDUAL_CHECK_EN
  logic sd_q, sd_d;
  logic sd_now;

  // Self-duality of the table as it will stand after this edge; the
  // last sample lands on the same edge that enters DONE, so the compare
  // works on tt_d rather than tt_q.
  always_comb begin
    sd_now = 1'b1;
    for (int unsigned i = 0; i < HALF; i++) begin
      sd_now = sd_now & (tt_d[i] ^ tt_d[TTW-1-i]);
    end
  end

  // Flag clears on launch and is captured once on DONE entry.
  always_comb begin
    sd_d = sd_q;
    if (launch) begin
      sd_d = 1'b0;
    end else if ((state_d == DONE) && (state_q != DONE)) begin
      sd_d = sd_now;
    end
  end

  // Self-dual flag register.
  always_ff @(posedge clk) begin
    if (!rst_n) sd_q <= 1'b0;
    else        sd_q <= sd_d;
  end

  assign bus.self_dual_o = sd_q;
`else
  assign bus.self_dual_o = 1'b0;
`endif

  assign busy         = (state_q != IDLE);
  assign bus.x_o      = x_q;
  assign bus.tt_o     = tt_q;
  assign bus.ones_o   = ones_q;
  assign bus.tt_valid = (state_q == DONE);

endmodule
